alu_wb_stage: RTL and testbench

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

---
 rtl/alu_wb_stage.sv | 163 ++++++++++++++++
 tb/tb_alu_wb_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// ALU-to-writeback 2-entry skid buffer with architectural flag capture and retire counter.
// Optional STICKY_OVF_EN adds a sticky overflow bit (StickyOvf) cleared by ClearSticky.
module alu_wb_stage #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEST_W = 4
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InResult,
    input  logic              InZero,
    input  logic              InOverflow,
    input  logic              InCarryOut,
    input  logic [DEST_W-1:0] InDest,
    input  logic              InWrEn,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutResult,
    output logic [DEST_W-1:0] OutDest,
    output logic              OutWrEn,
    output logic [2:0]        StatusFlags,
    output logic [15:0]       RetireCount
`ifdef STICKY_OVF_EN
    ,
    input  logic              ClearSticky,
    output logic              StickyOvf
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DEST_W-1:0] dest;
        logic              wr_en;
        logic              zero;
        logic              ovf;
        logic              carry;
    } entry_t;

    state_t state;
    state_t state_next;
    entry_t in_entry;
    entry_t out_q;
    entry_t skid_q;

    logic in_xfer;
    logic out_xfer;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;
    logic clear_wr_en;

    assign in_entry = {InResult, InDest, InWrEn, InZero, InOverflow, InCarryOut};
    assign in_xfer  = InValid && InReady;
    assign out_xfer = OutValid && OutReady;

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus data-path load strobes
    always_comb begin
        state_next    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        clear_wr_en   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next  = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_in = 1'b1;
                end else if (in_xfer) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_xfer) begin
                    state_next  = EMPTY;
                    clear_wr_en = 1'b1;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_next    = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshakes come straight from flops so OutReady never reaches InReady combinationally
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            InReady  <= 1'b1;
            OutValid <= 1'b0;
        end else begin
            InReady  <= (state_next != FULL);
            OutValid <= (state_next != EMPTY);
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_in) begin
                out_q <= in_entry;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end else if (clear_wr_en) begin
                out_q.wr_en <= 1'b0;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign OutResult = out_q.result;
    assign OutDest   = out_q.dest;
    assign OutWrEn   = out_q.wr_en;

    // Flags retire with the entry whether or not it writes the register file
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            StatusFlags <= 3'b000;
            RetireCount <= 16'd0;
        end else if (out_xfer) begin
            StatusFlags <= {out_q.zero, out_q.ovf, out_q.carry};
            RetireCount <= RetireCount + 16'd1;
        end
    end

`ifdef STICKY_OVF_EN
    // Set wins over clear on the same edge
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            StickyOvf <= 1'b0;
        end else if (out_xfer && out_q.ovf) begin
            StickyOvf <= 1'b1;
        end else if (ClearSticky) begin
            StickyOvf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: queue-based reference model, directed and random stimulus.
// Define STICKY_OVF_EN to also exercise the sticky overflow bit.
module tb_alu_wb_stage;

    typedef struct packed {
        logic [23:0] res;
        logic [3:0]  dest;
        logic        we;
        logic        z;
        logic        v;
        logic        c;
    } entry_t;

    logic        Clock;
    logic        ResetN;
    logic        InValid;
    logic        InReady;
    logic [23:0] InResult;
    logic        InZero;
    logic        InOverflow;
    logic        InCarryOut;
    logic [3:0]  InDest;
    logic        InWrEn;
    logic        OutValid;
    logic        OutReady;
    logic [23:0] OutResult;
    logic [3:0]  OutDest;
    logic        OutWrEn;
    logic [2:0]  StatusFlags;
    logic [15:0] RetireCount;
`ifdef STICKY_OVF_EN
    logic        ClearSticky;
    logic        StickyOvf;
`endif

    int tests  = 0;
    int failed = 0;

    entry_t      q[$];
    entry_t      m_last;
    logic [2:0]  m_status;
    logic [15:0] m_retire;
    logic        m_sticky;
    logic        last_in_x;

    alu_wb_stage #(.DATA_W(24), .DEST_W(4)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .InValid    (InValid),
        .InReady    (InReady),
        .InResult   (InResult),
        .InZero     (InZero),
        .InOverflow (InOverflow),
        .InCarryOut (InCarryOut),
        .InDest     (InDest),
        .InWrEn     (InWrEn),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutResult  (OutResult),
        .OutDest    (OutDest),
        .OutWrEn    (OutWrEn),
        .StatusFlags(StatusFlags),
        .RetireCount(RetireCount)
`ifdef STICKY_OVF_EN
        ,
        .ClearSticky(ClearSticky),
        .StickyOvf  (StickyOvf)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic entry_t mk(input logic [23:0] r, input logic [3:0] d,
                                  input logic we, input logic z, input logic v, input logic c);
        entry_t e;
        e = {r, d, we, z, v, c};
        return e;
    endfunction

    function automatic entry_t rnd_entry();
        entry_t e;
        e = {24'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)};
        return e;
    endfunction

    // Per-cycle comparison of every DUT output against the model
    task automatic compare();
        int n;
        n = q.size();
        chk("in_ready",     32'(InReady),     32'(n < 2));
        chk("out_valid",    32'(OutValid),    32'(n > 0));
        chk("out_result",   32'(OutResult),   32'(m_last.res));
        chk("out_dest",     32'(OutDest),     32'(m_last.dest));
        chk("out_wr_en",    32'(OutWrEn),     32'((n > 0) ? m_last.we : 1'b0));
        chk("status_flags", 32'(StatusFlags), 32'(m_status));
        chk("retire_count", 32'(RetireCount), 32'(m_retire));
`ifdef STICKY_OVF_EN
        chk("sticky_ovf",   32'(StickyOvf),   32'(m_sticky));
`endif
    endtask

    // One clock: drive inputs, advance model across the edge, compare on the falling edge
    task automatic cycle(input logic rst_n, input logic iv, input entry_t e,
                         input logic ordy, input logic clr);
        bit     in_x;
        bit     out_x;
        entry_t p;
        ResetN     = rst_n;
        InValid    = iv;
        InResult   = e.res;
        InDest     = e.dest;
        InWrEn     = e.we;
        InZero     = e.z;
        InOverflow = e.v;
        InCarryOut = e.c;
        OutReady   = ordy;
`ifdef STICKY_OVF_EN
        ClearSticky = clr;
`endif
        in_x  = iv && (q.size() < 2);
        out_x = (q.size() > 0) && ordy;
        @(posedge Clock);
        if (!rst_n) begin
            q.delete();
            m_last   = '0;
            m_status = 3'b000;
            m_retire = 16'd0;
            m_sticky = 1'b0;
        end else begin
            if (out_x) begin
                p        = q.pop_front();
                m_status = {p.z, p.v, p.c};
                m_retire = m_retire + 16'd1;
                if (p.v) m_sticky = 1'b1;
                else if (clr) m_sticky = 1'b0;
            end else if (clr) begin
                m_sticky = 1'b0;
            end
            if (in_x) q.push_back(e);
            if (q.size() > 0) m_last = q[0];
        end
        last_in_x = in_x && rst_n;
        @(negedge Clock);
        compare();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        entry_t pe;
        bit     pend;
        int     bubbles;
        q.delete();
        m_last = '0; m_status = '0; m_retire = '0; m_sticky = 1'b0; last_in_x = 1'b0;
        ResetN = 1'b0; InValid = 1'b0; InResult = '0; InDest = '0; InWrEn = 1'b0;
        InZero = 1'b0; InOverflow = 1'b0; InCarryOut = 1'b0; OutReady = 1'b0;
`ifdef STICKY_OVF_EN
        ClearSticky = 1'b0;
`endif

        // Reset values
        do_reset();
        do_reset();
        chk("rst_out_valid", 32'(OutValid), 32'd0);
        chk("rst_in_ready", 32'(InReady), 32'd1);
        chk("rst_retire", 32'(RetireCount), 32'd0);
        chk("rst_status", 32'(StatusFlags), 32'd0);
        chk("rst_out_result", 32'(OutResult), 32'd0);

        // Single entry latency and retire count
        cycle(1'b1, 1'b1, mk(24'h00002A, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
        chk("lat_out_valid", 32'(OutValid), 32'd1);
        chk("lat_out_result", 32'(OutResult), 32'h2A);
        chk("lat_out_dest", 32'(OutDest), 32'd3);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("lat_retire", 32'(RetireCount), 32'd1);
        chk("lat_wr_en_idle", 32'(OutWrEn), 32'd0);
        chk("lat_hold_result", 32'(OutResult), 32'h2A);

        // Backpressure fills the skid slot, then drains in order
        do_reset();
        cycle(1'b1, 1'b1, mk(24'h000001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, mk(24'h000002, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        chk("bp_in_ready", 32'(InReady), 32'd0);
        cycle(1'b1, 1'b1, mk(24'h000003, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        chk("bp_held_first", 32'(OutResult), 32'h1);
        cycle(1'b1, 1'b1, mk(24'h000003, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
        chk("bp_second", 32'(OutResult), 32'h2);
        cycle(1'b1, 1'b1, mk(24'h000003, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
        chk("bp_third", 32'(OutResult), 32'h3);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("bp_drained", 32'(OutValid), 32'd0);
        chk("bp_retire", 32'(RetireCount), 32'd3);

        // Status flags follow each transferred entry
        do_reset();
        cycle(1'b1, 1'b1, mk(24'h000000, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, mk(24'h000010, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        chk("flags_111", 32'(StatusFlags), 32'b111);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("flags_001", 32'(StatusFlags), 32'b001);

        // Reset while full discards buffered entries
        cycle(1'b1, 1'b1, mk(24'hAAAAAA, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, mk(24'hBBBBBB, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        chk("full_in_ready", 32'(InReady), 32'd0);
        do_reset();
        chk("midrst_out_valid", 32'(OutValid), 32'd0);
        chk("midrst_in_ready", 32'(InReady), 32'd1);
        chk("midrst_retire", 32'(RetireCount), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("midrst_no_ghost", 32'(OutValid), 32'd0);

`ifdef STICKY_OVF_EN
        do_reset();
        cycle(1'b1, 1'b1, mk(24'h1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, mk(24'h2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
        chk("sticky_set", 32'(StickyOvf), 32'd1);
        cycle(1'b1, 1'b1, mk(24'h3, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0);
        chk("sticky_keep", 32'(StickyOvf), 32'd1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        chk("sticky_set_wins", 32'(StickyOvf), 32'd1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        chk("sticky_clear", 32'(StickyOvf), 32'd0);
`endif

        // Continuous streaming: 65536 transfers wrap the retire counter, no bubbles
        do_reset();
        bubbles = 0;
        for (int i = 0; i < 65537; i++) begin
            cycle(1'b1, 1'b1, rnd_entry(), 1'b1, 1'b0);
            if (OutValid !== 1'b1) bubbles++;
        end
        chk("stream_wrap", 32'(RetireCount), 32'd0);
        chk("stream_bubbles", 32'(bubbles), 32'd0);

        // Random traffic; upstream holds its entry until accepted
        do_reset();
        pend = 1'b0;
        pe   = '0;
        for (int i = 0; i < 4000; i++) begin
            if (!pend || last_in_x) begin
                pend = ($urandom_range(0, 3) != 0);
                pe   = rnd_entry();
            end
            if ($urandom_range(0, 299) == 0) begin
                cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
                pend = 1'b0;
            end else begin
                cycle(1'b1, pend, pe, 1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 7) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
